adxl355_ringbuf: RTL and testbench

//  Downstream of the ADXL355 SPI reader: takes its byte stream (wrdata/wr16) and sync pulse, assembles fixed-size

---
 rtl/adxl355_pkg.sv | 18 +
 rtl/adxl355_ringbuf_ram.sv | 27 ++
 rtl/adxl355_ringbuf.sv | 173 +++++++++++++++++
 tb/tb_adxl355_ringbuf.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adxl355_pkg.sv
// Shared constants, FSM encoding and pointer helper for the ADXL355 sample ring buffer.
package adxl355_pkg;

  localparam int RAM_LEN_DEFAULT    = 6144;
  localparam int SAMPLE_BYTES_XYZ16 = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    SKIP = 2'd2
  } rb_state_e;

  // Increment with wrap from len-1 back to 0; len need not be a power of two.
  function automatic logic [15:0] ptr_inc(input logic [15:0] ptr, input logic [15:0] len);
    return (ptr == len - 16'd1) ? 16'd0 : ptr + 16'd1;
  endfunction

endpackage

// File: rtl/adxl355_ringbuf_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port (old data on same-address collision).
module adxl355_ringbuf_ram #(
  parameter int DEPTH     = 6144,
  parameter int ADDR_BITS = 13
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [7:0]           wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [7:0]           rdata
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto block RAM; only the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) rdata <= 8'd0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/adxl355_ringbuf.sv
// Frame-aligned circular sample buffer between the ADXL355 reader and the ESP32 SPI slave.
// Optional PPS tagging of frame start addresses: define ADXL355_RINGBUF_PPS_TAG_EN.
module adxl355_ringbuf
  import adxl355_pkg::*;
#(
  parameter int RAM_LEN      = RAM_LEN_DEFAULT,
  parameter int ADDR_BITS    = 13,
  parameter int SAMPLE_BYTES = SAMPLE_BYTES_XYZ16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_sync,
  input  logic                 i_wr,
  input  logic [7:0]           i_data,
  input  logic [ADDR_BITS-1:0] i_rd_ptr,
  input  logic [ADDR_BITS-1:0] i_rd_addr,
  output logic [7:0]           o_rd_data,
  output logic [ADDR_BITS-1:0] o_wr_ptr,
  output logic [15:0]          o_frame_cnt,
  output logic [7:0]           o_drop_cnt,
  output logic                 o_overflow,
  input  logic                 i_clr,
  input  logic                 i_pps,
  output logic [ADDR_BITS-1:0] o_pps_ptr,
  output logic                 o_pps_valid
);

  localparam int                   BC_BITS = $clog2(SAMPLE_BYTES + 1);
  localparam logic [ADDR_BITS:0]   LEN_W   = (ADDR_BITS+1)'(RAM_LEN);
  localparam logic [ADDR_BITS:0]   ONE_W   = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS:0]   NEED_W  = (ADDR_BITS+1)'(SAMPLE_BYTES);
  localparam logic [BC_BITS-1:0]   LAST_BC = BC_BITS'(SAMPLE_BYTES - 1);

  rb_state_e            state, state_n;
  logic [ADDR_BITS-1:0] fs, fs_n, wa, wa_n, wa_cur;
  logic [BC_BITS-1:0]   bc, bc_n, bc_cur;
  logic [15:0]          frame_cnt;
  logic [7:0]           drop_cnt, drop_n;
  logic [8:0]           drop_sum;
  logic                 overflow;
  logic [ADDR_BITS:0]   used, free;
  logic [1:0]           drop_inc;
  logic                 in_fill, ovf_set, start_ok, commit, ram_we;

  // Occupancy is measured from the committed frame start, so partial fills never count as used.
  always_comb begin
    if (fs >= i_rd_ptr) used = {1'b0, fs} - {1'b0, i_rd_ptr};
    else                used = {1'b0, fs} + LEN_W - {1'b0, i_rd_ptr};
    free = LEN_W - ONE_W - used;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    state_n  = state;
    fs_n     = fs;
    wa_cur   = wa;
    bc_cur   = bc;
    in_fill  = (state == FILL);
    drop_inc = 2'd0;
    ovf_set  = 1'b0;
    start_ok = 1'b0;
    commit   = 1'b0;
    ram_we   = 1'b0;

    // Sync is resolved before the byte so a coincident byte becomes the first byte of the new frame.
    if (i_sync) begin
      wa_cur = fs;
      bc_cur = '0;
      if (state == FILL) drop_inc = drop_inc + 2'd1;
      if (free >= NEED_W) begin
        start_ok = 1'b1;
        in_fill  = 1'b1;
        state_n  = FILL;
      end else begin
        in_fill  = 1'b0;
        state_n  = SKIP;
        drop_inc = drop_inc + 2'd1;
        ovf_set  = 1'b1;
      end
    end

    wa_n = wa_cur;
    bc_n = bc_cur;
    if (in_fill && i_wr) begin
      ram_we = 1'b1;
      wa_n   = ADDR_BITS'(ptr_inc(16'(wa_cur), 16'(RAM_LEN)));
      bc_n   = bc_cur + BC_BITS'(1);
      if (bc_cur == LAST_BC) begin
        fs_n    = wa_n;
        commit  = 1'b1;
        state_n = IDLE;
      end
    end

    drop_sum = {1'b0, (i_clr ? 8'd0 : drop_cnt)} + {7'd0, drop_inc};
    drop_n   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fs        <= '0;
      wa        <= '0;
      bc        <= '0;
      frame_cnt <= 16'd0;
      drop_cnt  <= 8'd0;
      overflow  <= 1'b0;
    end else begin
      state    <= state_n;
      fs       <= fs_n;
      wa       <= wa_n;
      bc       <= bc_n;
      drop_cnt <= drop_n;
      if (commit) frame_cnt <= frame_cnt + 16'd1;
      if (ovf_set)    overflow <= 1'b1;
      else if (i_clr) overflow <= 1'b0;
    end
  end

  assign o_wr_ptr    = fs;
  assign o_frame_cnt = frame_cnt;
  assign o_drop_cnt  = drop_cnt;
  assign o_overflow  = overflow;

  adxl355_ringbuf_ram #(
    .DEPTH     (RAM_LEN),
    .ADDR_BITS (ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (wa_cur),
    .wdata (i_data),
    .raddr (i_rd_addr),
    .rdata (o_rd_data)
  );

`ifdef ADXL355_RINGBUF_PPS_TAG_EN
  logic [2:0]           pps_sync;
  logic                 pps_armed, pps_valid;
  logic [ADDR_BITS-1:0] pps_ptr;

  // pps_sync[1:0] is the synchronizer, pps_sync[2] the previous value for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      pps_sync  <= 3'd0;
      pps_armed <= 1'b0;
      pps_ptr   <= '0;
      pps_valid <= 1'b0;
    end else begin
      pps_sync <= {pps_sync[1:0], i_pps};
      if (pps_sync[1] && !pps_sync[2]) pps_armed <= 1'b1;
      else if (start_ok)               pps_armed <= 1'b0;
      if (start_ok && pps_armed) begin
        pps_ptr   <= fs;
        pps_valid <= 1'b1;
      end else if (i_clr) begin
        pps_valid <= 1'b0;
      end
    end
  end

  assign o_pps_ptr   = pps_ptr;
  assign o_pps_valid = pps_valid;
`else
  logic unused_pps;
  assign unused_pps  = i_pps | start_ok;
  assign o_pps_ptr   = '0;
  assign o_pps_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adxl355_ringbuf.sv
// Scoreboard bench for adxl355_ringbuf: a 6144-byte and a 16-byte instance share one byte stream.
`timescale 1ns/1ps
module tb_adxl355_ringbuf;

  localparam int NB    = 2;
  localparam int LEN_B = 6144;
  localparam int AB_B  = 13;
  localparam int LEN_S = 16;
  localparam int AB_S  = 4;
  localparam int SB    = 6;

  logic clk = 1'b0;
  always #12.5 clk = ~clk;

  logic            rst = 1'b1, i_sync = 1'b0, i_wr = 1'b0, i_clr = 1'b0, i_pps = 1'b0;
  logic [7:0]      i_data = 8'd0;
  logic [AB_B-1:0] rd_ptr_b = '0, rd_addr_b = '0, wr_ptr_b, pps_ptr_b;
  logic [AB_S-1:0] rd_ptr_s = '0, rd_addr_s = '0, wr_ptr_s, pps_ptr_s;
  logic [7:0]      rd_data_b, rd_data_s, drop_cnt_b, drop_cnt_s;
  logic [15:0]     frame_cnt_b, frame_cnt_s;
  logic            overflow_b, overflow_s, pps_valid_b, pps_valid_s;

  adxl355_ringbuf #(.RAM_LEN(LEN_B), .ADDR_BITS(AB_B), .SAMPLE_BYTES(SB)) dut (
    .clk(clk), .rst(rst), .i_sync(i_sync), .i_wr(i_wr), .i_data(i_data),
    .i_rd_ptr(rd_ptr_b), .i_rd_addr(rd_addr_b), .o_rd_data(rd_data_b),
    .o_wr_ptr(wr_ptr_b), .o_frame_cnt(frame_cnt_b), .o_drop_cnt(drop_cnt_b),
    .o_overflow(overflow_b), .i_clr(i_clr), .i_pps(i_pps),
    .o_pps_ptr(pps_ptr_b), .o_pps_valid(pps_valid_b)
  );

  adxl355_ringbuf #(.RAM_LEN(LEN_S), .ADDR_BITS(AB_S), .SAMPLE_BYTES(SB)) dut_s (
    .clk(clk), .rst(rst), .i_sync(i_sync), .i_wr(i_wr), .i_data(i_data),
    .i_rd_ptr(rd_ptr_s), .i_rd_addr(rd_addr_s), .o_rd_data(rd_data_s),
    .o_wr_ptr(wr_ptr_s), .o_frame_cnt(frame_cnt_s), .o_drop_cnt(drop_cnt_s),
    .o_overflow(overflow_s), .i_clr(i_clr), .i_pps(i_pps),
    .o_pps_ptr(pps_ptr_s), .o_pps_valid(pps_valid_s)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: frames are buffered whole and copied into memory only when complete.
  int         m_len [NB] = '{LEN_B, LEN_S};
  int         m_fs [NB], m_rd [NB], m_nb [NB], m_frames [NB], m_drop [NB];
  bit         m_act [NB], m_ovf [NB];
  logic [7:0] m_buf [NB][SB];
  logic [7:0] m_mem [NB][LEN_B];
  int         cq_b[$], cq_s[$], rq_b[$], rq_s[$];
  logic       rd_iss_b = 1'b0, rd_iss_s = 1'b0, rd_vld_b = 1'b0, rd_vld_s = 1'b0;
  int         prev_b = 0, prev_s = 0;

  function automatic int used_of(input int k);
    return (m_fs[k] - m_rd[k] + m_len[k]) % m_len[k];
  endfunction

  task automatic model_step(input int k, input bit sync, input bit wr, input logic [7:0] d,
                            input bit clr);
    int inc;
    bit ovf_now;
    inc = 0;
    ovf_now = 0;
    if (sync) begin
      if (m_act[k]) inc++;
      if (m_len[k] - 1 - used_of(k) >= SB) begin
        m_act[k] = 1;
        m_nb[k]  = 0;
      end else begin
        m_act[k] = 0;
        inc++;
        ovf_now = 1;
      end
    end
    if (wr && m_act[k]) begin
      m_buf[k][m_nb[k]] = d;
      m_nb[k]++;
      if (m_nb[k] == SB) begin
        for (int i = 0; i < SB; i++) m_mem[k][(m_fs[k] + i) % m_len[k]] = m_buf[k][i];
        m_fs[k]     = (m_fs[k] + SB) % m_len[k];
        m_frames[k] = (m_frames[k] + 1) % 65536;
        m_act[k]    = 0;
        if (k == 0) cq_b.push_back(m_fs[k]);
        else        cq_s.push_back(m_fs[k]);
      end
    end
    if (clr) begin
      m_drop[k] = 0;
      m_ovf[k]  = 0;
    end
    m_drop[k] = (m_drop[k] + inc > 255) ? 255 : m_drop[k] + inc;
    if (ovf_now) m_ovf[k] = 1;
  endtask

  task automatic step(input bit sync, input bit wr, input logic [7:0] d, input bit clr);
    i_sync = sync;
    i_wr   = wr;
    i_data = d;
    i_clr  = clr;
    for (int k = 0; k < NB; k++) model_step(k, sync, wr, d, clr);
    @(posedge clk);
    @(negedge clk);
    i_sync = 1'b0;
    i_wr   = 1'b0;
    i_clr  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d0);
    step(1, 0, 8'd0, 0);
    for (int i = 0; i < SB; i++) step(0, 1, d0 + 8'(i), 0);
  endtask

  task automatic set_rd(input int k, input int v);
    m_rd[k] = v;
    if (k == 0) rd_ptr_b = AB_B'(v);
    else        rd_ptr_s = AB_S'(v);
  endtask

  task automatic rd_req(input int k, input int addr);
    if (k == 0) begin
      rd_addr_b = AB_B'(addr);
      rd_iss_b  = 1'b1;
      rq_b.push_back(int'(m_mem[0][addr]));
    end else begin
      rd_addr_s = AB_S'(addr);
      rd_iss_s  = 1'b1;
      rq_s.push_back(int'(m_mem[1][addr]));
    end
    @(posedge clk);
    @(negedge clk);
    rd_iss_b = 1'b0;
    rd_iss_s = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NB; k++) begin
      m_fs[k] = 0; m_nb[k] = 0; m_frames[k] = 0; m_drop[k] = 0;
      m_act[k] = 0; m_ovf[k] = 0;
      set_rd(k, 0);
    end
    cq_b.delete();
    cq_s.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_status(input int k, input string tag);
    if (k == 0) begin
      check({tag, "_wrptr_b"}, int'(wr_ptr_b), m_fs[0]);
      check({tag, "_frames_b"}, int'(frame_cnt_b), m_frames[0]);
      check({tag, "_drop_b"}, int'(drop_cnt_b), m_drop[0]);
      check({tag, "_ovf_b"}, int'(overflow_b), int'(m_ovf[0]));
    end else begin
      check({tag, "_wrptr_s"}, int'(wr_ptr_s), m_fs[1]);
      check({tag, "_frames_s"}, int'(frame_cnt_s), m_frames[1]);
      check({tag, "_drop_s"}, int'(drop_cnt_s), m_drop[1]);
      check({tag, "_ovf_s"}, int'(overflow_s), int'(m_ovf[1]));
    end
  endtask

  always @(posedge clk) begin
    rd_vld_b <= rd_iss_b;
    rd_vld_s <= rd_iss_s;
  end

  // Monitor: pops the scoreboard whenever a read result or a new commit pointer appears.
  always @(negedge clk) begin
    if (rd_vld_b) begin
      if (rq_b.size() == 0) check("rd_b_unexpected", int'(rd_data_b), -1);
      else                  check("rd_b", int'(rd_data_b), rq_b.pop_front());
    end
    if (rd_vld_s) begin
      if (rq_s.size() == 0) check("rd_s_unexpected", int'(rd_data_s), -1);
      else                  check("rd_s", int'(rd_data_s), rq_s.pop_front());
    end
    if (!rst) begin
      if (int'(wr_ptr_b) != prev_b) begin
        if (cq_b.size() == 0) check("commit_b_unexpected", int'(wr_ptr_b), -1);
        else                  check("commit_b", int'(wr_ptr_b), cq_b.pop_front());
      end
      if (int'(wr_ptr_s) != prev_s) begin
        if (cq_s.size() == 0) check("commit_s_unexpected", int'(wr_ptr_s), -1);
        else                  check("commit_s", int'(wr_ptr_s), cq_s.pop_front());
      end
    end
    prev_b = int'(wr_ptr_b);
    prev_s = int'(wr_ptr_s);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_pps_v, exp_pps_p, r, k, u;

    // Reset values, sampled while rst is still high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rd_data", int'(rd_data_b), 0);
    check("reset_wrptr", int'(wr_ptr_b), 0);
    check("reset_frames", int'(frame_cnt_b), 0);
    check("reset_drop", int'(drop_cnt_b), 0);
    check("reset_ovf", int'(overflow_b), 0);
    check("reset_pps_valid", int'(pps_valid_b), 0);
    do_reset();

    // One complete frame; the commit pointer moves only after the 6th byte.
    step(1, 0, 8'd0, 0);
    for (int i = 0; i < SB; i++) begin
      step(0, 1, 8'(i + 1), 0);
      if (i == SB - 2) check("t1_wrptr_before_last", int'(wr_ptr_b), 0);
    end
    check("t1_wrptr_after_last", int'(wr_ptr_b), 6);
    check("t1_frames", int'(frame_cnt_b), 1);
    for (int a = 0; a < SB; a++) rd_req(0, a);

    // Abandoned partial frame rewinds to the frame start.
    do_reset();
    step(1, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'h11 * 8'(i + 1), 0);
    step(1, 0, 8'd0, 0);
    for (int i = 0; i < SB; i++) step(0, 1, 8'hAA + 8'(i), 0);
    check("t2_drop", int'(drop_cnt_b), 1);
    check("t2_ovf", int'(overflow_b), 0);
    check("t2_wrptr", int'(wr_ptr_b), 6);
    for (int a = 0; a < SB; a++) rd_req(0, a);

    // Small ring fills up, drops, then wraps once the reader catches up.
    do_reset();
    send_frame(8'h30);
    send_frame(8'h40);
    send_frame(8'h48);
    check("t3_wrptr_s", int'(wr_ptr_s), 12);
    check("t3_drop_s", int'(drop_cnt_s), 1);
    check("t3_ovf_s", int'(overflow_s), 1);
    chk_status(0, "t3");
    set_rd(1, 12);
    send_frame(8'h50);
    check("t3_wrap_wrptr_s", int'(wr_ptr_s), 2);
    check("t3_wrap_frames_s", int'(frame_cnt_s), 3);
    for (int i = 0; i < SB; i++) rd_req(1, (12 + i) % LEN_S);

    // Clear coinciding with a drop: the drop wins, then a lone clear empties both.
    send_frame(8'h60);
    step(1, 0, 8'd0, 1);
    check("clr_drop_same_cycle_drop_s", int'(drop_cnt_s), 1);
    check("clr_drop_same_cycle_ovf_s", int'(overflow_s), 1);
    step(0, 0, 8'd0, 1);
    check("clr_alone_drop_s", int'(drop_cnt_s), 0);
    check("clr_alone_ovf_s", int'(overflow_s), 0);
    chk_status(0, "clr");

    // Sync and first byte in the same cycle; the 7th byte is ignored.
    do_reset();
    step(1, 1, 8'h5A, 0);
    for (int i = 1; i < SB; i++) step(0, 1, 8'h5A + 8'(i), 0);
    step(0, 1, 8'h77, 0);
    check("t4_frames", int'(frame_cnt_b), 1);
    check("t4_wrptr", int'(wr_ptr_b), 6);
    rd_req(0, 0);
    rd_req(0, 5);

    // Reset mid-frame discards the partial frame.
    do_reset();
    send_frame(8'h90);
    step(1, 0, 8'd0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 8'hB0 + 8'(i), 0);
    do_reset();
    check("t5_wrptr", int'(wr_ptr_b), 0);
    check("t5_frames", int'(frame_cnt_b), 0);
    check("t5_drop", int'(drop_cnt_b), 0);
    send_frame(8'hC0);
    check("t5_next_wrptr", int'(wr_ptr_b), 6);
    rd_req(0, 0);

    // PPS edge in the middle of the third frame tags the next accepted frame start.
    do_reset();
    send_frame(8'h10);
    send_frame(8'h20);
    step(1, 0, 8'd0, 0);
    step(0, 1, 8'h30, 0);
    i_pps = 1'b1;
    for (int i = 1; i < SB; i++) step(0, 1, 8'h30 + 8'(i), 0);
    i_pps = 1'b0;
    step(1, 0, 8'd0, 0);
`ifdef ADXL355_RINGBUF_PPS_TAG_EN
    exp_pps_v = 1;
    exp_pps_p = 18;
`else
    exp_pps_v = 0;
    exp_pps_p = 0;
`endif
    check("t6_pps_valid", int'(pps_valid_b), exp_pps_v);
    check("t6_pps_ptr", int'(pps_ptr_b), exp_pps_p);
    step(0, 0, 8'd0, 1);
    check("t6_pps_valid_after_clr", int'(pps_valid_b), 0);
    check("t6_pps_ptr_after_clr", int'(pps_ptr_b), exp_pps_p);

    // Randomized traffic against the model.
    do_reset();
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      k = $urandom_range(0, NB - 1);
      if (r < 15)      send_frame(8'($urandom));
      else if (r < 25) step(1, $urandom_range(0, 1), 8'($urandom), 0);
      else if (r < 60) step(0, 1, 8'($urandom), 0);
      else if (r < 64) step(0, 0, 8'd0, 1);
      else if (r < 76) begin
        u = used_of(k);
        set_rd(k, (m_rd[k] + $urandom_range(0, u)) % m_len[k]);
      end else if (r < 90) begin
        u = used_of(k);
        if (u > 0) rd_req(k, (m_rd[k] + $urandom_range(0, u - 1)) % m_len[k]);
      end else step(0, 0, 8'd0, 0);
      if (it % 25 == 24) begin
        chk_status(0, "rand");
        chk_status(1, "rand");
      end
    end

    repeat (3) @(negedge clk);
    check("commit_q_b_drained", cq_b.size(), 0);
    check("commit_q_s_drained", cq_s.size(), 0);
    check("read_q_b_drained", rq_b.size(), 0);
    check("read_q_s_drained", rq_s.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
